exu_muldiv: RTL

Parametrised multi-cycle multiply/divide execute unit for the RV32M/RV64M "M" instructions, sitting beside the single-cycle ALU in the execute stage. It accepts one operation at a time from decode/execute and iterates BPC result bits per cycle. It stalls the PC via hold_o while busy and delivers a register write-back to the register file.

---
 rtl/exu_muldiv_pkg.sv | 52 +++++
 rtl/exu_muldiv_step.sv | 43 ++++
 rtl/exu_muldiv.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/exu_muldiv_pkg.sv
// Shared definitions for the multi-cycle M-extension execute unit.
// Opcodes follow funct3; helpers classify operand signedness.
package exu_muldiv_pkg;

  localparam int MD_XLEN = 32;

  localparam logic [4:0] ZERO_REG = 5'd0;

  localparam logic [2:0] MD_OP_MUL    = 3'd0;
  localparam logic [2:0] MD_OP_MULH   = 3'd1;
  localparam logic [2:0] MD_OP_MULHSU = 3'd2;
  localparam logic [2:0] MD_OP_MULHU  = 3'd3;
  localparam logic [2:0] MD_OP_DIV    = 3'd4;
  localparam logic [2:0] MD_OP_DIVU   = 3'd5;
  localparam logic [2:0] MD_OP_REM    = 3'd6;
  localparam logic [2:0] MD_OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_STATE_IDLE = 2'd0,
    MD_STATE_CALC = 2'd1,
    MD_STATE_DONE = 2'd2
  } md_state_e;

  function automatic logic md_op1_signed(
    input logic [2:0] op
  );
    return op inside {MD_OP_MUL, MD_OP_MULH,
                      MD_OP_MULHSU, MD_OP_DIV,
                      MD_OP_REM};
  endfunction

  function automatic logic md_op2_signed(
    input logic [2:0] op
  );
    return op inside {MD_OP_MUL, MD_OP_MULH,
                      MD_OP_DIV, MD_OP_REM};
  endfunction

  function automatic logic md_is_div(
    input logic [2:0] op
  );
    return op inside {MD_OP_DIV, MD_OP_DIVU,
                      MD_OP_REM, MD_OP_REMU};
  endfunction

  function automatic logic md_is_rem(
    input logic [2:0] op
  );
    return op inside {MD_OP_REM, MD_OP_REMU};
  endfunction

endpackage

// File: rtl/exu_muldiv_step.sv
// One BPC-bit iteration: shift-add multiply or restoring divide
// on the {hi,lo} accumulator pair, operating on magnitudes only.
module exu_muldiv_step #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] opnd_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   t;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  always_comb begin
    hi = hi_i;
    lo = lo_i;
    t  = '0;
    for (int i = 0; i < BPC; i++) begin
      if (is_div_i) begin
        t  = {hi, lo[XLEN-1]};
        lo = {lo[XLEN-2:0], 1'b0};
        if (t >= {1'b0, opnd_i}) begin
          t     = t - {1'b0, opnd_i};
          lo[0] = 1'b1;
        end
        hi = t[XLEN-1:0];
      end else begin
        t  = {1'b0, hi}
           + {1'b0, opnd_i & {XLEN{lo[0]}}};
        lo = {t[0], lo[XLEN-1:1]};
        hi = t[XLEN:1];
      end
    end
    hi_o = hi;
    lo_o = lo;
  end

endmodule

// File: rtl/exu_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit, BPC bits per cycle.
// Optional MULDIV_EARLY_OUT_EN resolves trivial operands in IDLE.
module exu_muldiv
  import exu_muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN,
  parameter int BPC  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  input  logic [2:0]      req_op_i,
  input  logic [4:0]      req_rd_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            flush_i,
  output logic            req_ready_o,
  output logic            res_valid_o,
  output logic [4:0]      res_rd_o,
  output logic [XLEN-1:0] res_data_o,
  output logic            hold_o
);

  localparam int N  = XLEN / BPC;
  localparam int CW = $clog2(N + 1);

  md_state_e       state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic            dz_q, dz_d;
  logic [4:0]      res_rd_q, res_rd_d;
  logic [XLEN-1:0] res_data_q, res_data_d;

  logic            s1, s2;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN-1:0] step_hi, step_lo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quo, rem, fin;

  assign s1   = md_op1_signed(req_op_i) & op1_i[XLEN-1];
  assign s2   = md_op2_signed(req_op_i) & op2_i[XLEN-1];
  assign abs1 = s1 ? -op1_i : op1_i;
  assign abs2 = s2 ? -op2_i : op2_i;

  exu_muldiv_step #(
    .XLEN (XLEN),
    .BPC  (BPC)
  ) u_step (
    .is_div_i (md_is_div(op_q)),
    .opnd_i   (opnd_q),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // Magnitude result, then sign fix; remainder follows dividend
  assign prod   = {hi_q, lo_q};
  assign prod_s = (sa_q ^ sb_q) ? -prod : prod;
  assign quo    = dz_q ? {XLEN{1'b1}}
                : ((sa_q ^ sb_q) ? -lo_q : lo_q);
  assign rem    = sa_q ? -hi_q : hi_q;

  always_comb begin
    fin = prod_s[2*XLEN-1:XLEN];
    if (md_is_div(op_q))
      fin = md_is_rem(op_q) ? rem : quo;
    else if (op_q == MD_OP_MUL)
      fin = prod_s[XLEN-1:0];
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic            ovf;
  logic            early;
  logic [XLEN-1:0] early_res;

  assign ovf = md_op2_signed(req_op_i)
             & (op1_i == {1'b1, {(XLEN-1){1'b0}}})
             & (&op2_i);
  assign early = (op1_i == '0) | (op2_i == '0)
               | (md_is_div(req_op_i) & ovf);

  always_comb begin
    early_res = '0;
    if (md_is_div(req_op_i)) begin
      if (op2_i == '0)
        early_res = md_is_rem(req_op_i) ?
                    op1_i : {XLEN{1'b1}};
      else if (ovf && !md_is_rem(req_op_i))
        early_res = op1_i;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= MD_STATE_IDLE;
      op_q       <= '0;
      rd_q       <= ZERO_REG;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      dz_q       <= 1'b0;
      res_rd_q   <= ZERO_REG;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      dz_q       <= dz_d;
      res_rd_q   <= res_rd_d;
      res_data_q <= res_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    opnd_d      = opnd_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    dz_d        = dz_q;
    res_rd_d    = res_rd_q;
    res_data_d  = res_data_q;
    res_valid_o = 1'b0;
    unique case (state_q)
      MD_STATE_IDLE: begin
        if (req_valid_i && !flush_i) begin
          state_d = MD_STATE_CALC;
          op_d    = req_op_i;
          rd_d    = req_rd_i;
          sa_d    = s1;
          sb_d    = s2;
          dz_d    = (op2_i == '0);
          cnt_d   = CW'(N);
          hi_d    = '0;
          lo_d    = md_is_div(req_op_i) ? abs1 : abs2;
          opnd_d  = md_is_div(req_op_i) ? abs2 : abs1;
`ifdef MULDIV_EARLY_OUT_EN
          if (early) begin
            state_d    = MD_STATE_DONE;
            res_rd_d   = req_rd_i;
            res_data_d = early_res;
          end
`endif
        end
      end
      MD_STATE_CALC: begin
        if (flush_i) begin
          state_d = MD_STATE_IDLE;
        end else if (cnt_q == '0) begin
          state_d    = MD_STATE_DONE;
          res_rd_d   = rd_q;
          res_data_d = fin;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q - CW'(1);
        end
      end
      MD_STATE_DONE: begin
        res_valid_o = !flush_i;
        state_d     = MD_STATE_IDLE;
      end
      default: state_d = MD_STATE_IDLE;
    endcase
  end

  assign req_ready_o = (state_q == MD_STATE_IDLE);
  assign hold_o      = ((state_q == MD_STATE_IDLE) & req_valid_i)
                     | (state_q == MD_STATE_CALC);
  assign res_rd_o    = res_rd_q;
  assign res_data_o  = res_data_q;

endmodule
